// File: rtl/grover_diffusion_serial.sv
// grover_diffusion_serial: Grover inversion-about-mean stage over valid/ready streams.
// Latency: 2 cycles from the last input accept to the first out_valid, then one result per cycle.
// Backpressure: in_ready only in LOAD; outputs are held while out_valid && !out_ready.
// Build option: define DIFFUSION_SAT_EN to clamp results to the W-bit range (default wraps).
module grover_diffusion_serial #(
  parameter int W      = 8,
  parameter int N_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [N_LOG2-1:0] out_idx,
  output logic              out_last,
  output logic              busy
);

  localparam int N = 1 << N_LOG2;
  localparam int AW = W + N_LOG2;

  typedef enum logic [1:0] {S_LOAD, S_MEAN, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_LOG2-1:0]   r_cnt;
  logic [AW-1:0]       r_acc;
  logic [W-1:0]        r_mean;
  logic [W-1:0]        r_buf [N];
  logic                r_out_valid;
  logic [W-1:0]        r_out_data;
  logic [N_LOG2-1:0]   r_out_idx;
  logic                r_out_last;

  logic                w_accept;
  logic                w_out_fire;
  logic [AW-1:0]       w_ext_in;
  logic [W-1:0]        w_mean_calc;
  logic [W-1:0]        w_sel_mean;
  logic [N_LOG2-1:0]   w_sel_idx;
  logic [W-1:0]        w_sel_buf;
  logic                w_sel_last;
  logic [W+1:0]        w_res;
  logic [W-1:0]        w_out;

  assign in_ready   = (r_state == S_LOAD) && !rst;
  assign busy       = (r_state != S_LOAD);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_idx    = r_out_idx;
  assign out_last   = r_out_last;

  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_ext_in   = {{N_LOG2{in_data[W-1]}}, in_data};

  // Floor mean is just the upper W bits of the accumulator (arithmetic shift by N_LOG2).
  assign w_mean_calc = r_acc[AW-1:N_LOG2];

  // In MEAN the first result is built straight from the accumulator so out_valid can rise
  // on the first DRAIN cycle; afterwards the registered mean and the next index are used.
  assign w_sel_mean = (r_state == S_MEAN) ? w_mean_calc : r_mean;
  assign w_sel_idx  = (r_state == S_MEAN) ? '0 : r_out_idx + 1'b1;
  assign w_sel_buf  = r_buf[w_sel_idx];
  assign w_sel_last = (w_sel_idx == N_LOG2'(N - 1));

  // 2*mean - a at W+2 bits cannot overflow for W-bit operands.
  assign w_res = {w_sel_mean[W-1], w_sel_mean, 1'b0} - {{2{w_sel_buf[W-1]}}, w_sel_buf};

`ifdef DIFFUSION_SAT_EN
  // Result fits when the top three bits agree; otherwise clamp by sign.
  always_comb begin
    w_out = w_res[W-1:0];
    if (!((w_res[W+1:W-1] == 3'b000) || (w_res[W+1:W-1] == 3'b111))) begin
      w_out = w_res[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  logic w_unused_res_hi;
  assign w_unused_res_hi = ^w_res[W+1:W];
  // Two's-complement wrap: keep the low W bits.
  always_comb begin
    w_out = w_res[W-1:0];
  end
`endif

  // Next-state logic: LOAD until N accepts, one MEAN cycle, DRAIN until the last handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_accept && (r_cnt == N_LOG2'(N - 1))) w_state_nxt = S_MEAN;
      S_MEAN:  w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_out_fire && r_out_last) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // State, counters, accumulator and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mean      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_acc + w_ext_in;
      end
      if (r_state == S_MEAN) begin
        r_mean      <= w_mean_calc;
        r_acc       <= '0;
        r_out_valid <= 1'b1;
        r_out_data  <= w_out;
        r_out_idx   <= w_sel_idx;
        r_out_last  <= w_sel_last;
      end
      if ((r_state == S_DRAIN) && w_out_fire) begin
        if (r_out_last) begin
          r_out_valid <= 1'b0;
        end else begin
          r_out_data <= w_out;
          r_out_idx  <= w_sel_idx;
          r_out_last <= w_sel_last;
        end
      end
    end
  end

  // Amplitude buffer; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_grover_diffusion_serial.sv
module tb_grover_diffusion_serial;
  localparam int W  = 8;
  localparam int NL = 3;
  localparam int N  = 8;

  typedef int frame_t[N];

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [NL-1:0] out_idx;
  logic          out_last;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  grover_diffusion_serial #(.W(W), .N_LOG2(NL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: floor mean by integer division corrected toward -inf, then 2*mean - a.
  function automatic frame_t model(input frame_t a);
    frame_t e;
    int sum = 0;
    int mean;
    int r;
    for (int i = 0; i < N; i++) sum += a[i];
    mean = sum / N;
    if (sum < 0 && (sum % N) != 0) mean -= 1;
    for (int i = 0; i < N; i++) begin
      r = 2 * mean - a[i];
`ifdef DIFFUSION_SAT_EN
      if (r > 127) r = 127;
      else if (r < -128) r = -128;
`else
      r = ((r % 256) + 256) % 256;
      if (r > 127) r -= 256;
`endif
      e[i] = r;
    end
    return e;
  endfunction

  function automatic frame_t rand_frame();
    frame_t a;
    for (int i = 0; i < N; i++) a[i] = int'($urandom_range(0, 255)) - 128;
    return a;
  endfunction

  // Push the first n samples; starts and ends at a negedge.
  task automatic send(input frame_t a, input int n);
    int i = 0;
    int waited = 0;
    logic acc;
    while (i < n && waited < 200) begin
      in_valid = 1'b1;
      in_data  = a[i][W-1:0];
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) i++;
      waited++;
    end
    in_valid = 1'b0;
    check("tx_cnt", i, n);
  endtask

  // Collect results up to stop_at handshakes. mode 0: ready always, 1: random ready,
  // 2: random ready plus a 5-cycle stall on idx 3. hold_in drives in_valid during drain.
  task automatic recv(input frame_t e, input int mode, input int stop_at, input int hold_in);
    int k = 0;
    int cyc = 0;
    int stall = 0;
    logic [W-1:0] held;
    logic holding = 1'b0;
    while (k < stop_at && cyc < 400) begin
      in_valid = hold_in[0];
      in_data  = W'($urandom);
      if (hold_in != 0) check("in_rdy_drain", int'(in_ready), 0);
      if (mode == 0) out_ready = 1'b1;
      else out_ready = 1'($urandom_range(0, 1));
      if (mode == 2 && out_valid && out_idx == 3'd3 && stall < 5) begin
        out_ready = 1'b0;
        if (holding) check("stall_dat", int'(out_data), int'(held));
        held = out_data;
        holding = 1'b1;
        stall++;
      end
      if (out_valid && out_ready) begin
        check("idx", int'(out_idx), k);
        check("dat", int'($signed(out_data)), e[k]);
        check("last", int'(out_last), int'(k == N - 1));
        k++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rx_cnt", k, stop_at);
    if (mode == 2) check("stall_len", stall, 5);
  endtask

  task automatic full_frame(input frame_t a, input int mode);
    frame_t e;
    e = model(a);
    send(a, N);
    recv(e, mode, N, 0);
    check("ov_end", int'(out_valid), 0);
    check("inr_end", int'(in_ready), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ov", int'(out_valid), 0);
    check("rst_inr", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_idx", int'(out_idx), 0);
    @(negedge clk);
  endtask

  initial begin
    frame_t a;
    frame_t e;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ov0", int'(out_valid), 0);
    check("rst_od0", int'(out_data), 0);
    check("rst_oi0", int'(out_idx), 0);
    check("rst_ol0", int'(out_last), 0);
    check("rst_busy0", int'(busy), 0);
    check("rst_inr0", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    check("inr_after_rst", int'(in_ready), 1);
    @(negedge clk);

    // Ramp with one inverted entry, plus first-output latency.
    a = '{1, 2, 3, -4, 5, 6, 7, 8};
    e = model(a);
    send(a, N);
    check("lat_a", int'(out_valid), 0);
    check("busy_mean", int'(busy), 1);
    @(negedge clk);
    check("lat_b", int'(out_valid), 1);
    recv(e, 0, N, 0);
    check("ov_end", int'(out_valid), 0);
    check("inr_end", int'(in_ready), 1);

    // Grover uniform, negative floor, overflow.
    a = '{32, 32, 32, 32, 32, -32, 32, 32};
    full_frame(a, 1);
    a = '{0, 0, -3, 0, 0, 0, 0, 0};
    full_frame(a, 1);
    a = '{-128, 127, 127, 127, 127, 127, 127, 127};
    full_frame(a, 0);

    // Backpressure with in_valid held through drain, then a frame to expose any stray accept.
    a = rand_frame();
    e = model(a);
    send(a, N);
    recv(e, 2, N, 1);
    check("ov_end_bp", int'(out_valid), 0);
    a = rand_frame();
    full_frame(a, 0);

    // Reset after 4 inputs, then a clean frame.
    a = rand_frame();
    send(a, 4);
    do_reset();
    a = rand_frame();
    full_frame(a, 1);

    // Reset at idx 2 of drain, then a clean frame.
    a = rand_frame();
    e = model(a);
    send(a, N);
    recv(e, 0, 2, 0);
    do_reset();
    a = rand_frame();
    full_frame(a, 0);

    // Random frames with random downstream readiness.
    for (int f = 0; f < 6; f++) begin
      a = rand_frame();
      full_frame(a, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/grover_diffusion_serial.md
Name: grover_diffusion_serial

Overview:
- Inversion-about-mean (diffusion) stage of the Grover iteration; the counterpart of the phase-invert oracle.
- Accepts 2^N_LOG2 signed amplitudes serially over a valid/ready stream and buffers them.
- Computes the floor mean, then streams out 2*mean - a_i in index order over a second valid/ready stream.
- Sits directly after the phase-invert stage; its output feeds the next oracle pass or the measurement logic.

Parameters:
- W, 8, amplitude width (signed two's complement).
- N_LOG2, 3, log2 of amplitude count; N = 2^N_LOG2 = 8 by default.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  W  signed amplitude a_i; index is implied by arrival order 0..N-1.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  W  signed diffused amplitude.
- out_idx  output  N_LOG2  index of out_data.
- out_last  output  1  high with out_valid on index N-1.
- busy  output  1  high in MEAN or DRAIN.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset (rst sampled high) forces:
  - state = LOAD;
  - load counter, drain counter and accumulator = 0;
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0.
- Buffer contents are don't-care after reset.
- in_ready = (state == LOAD) && !rst, combinational.
- State LOAD:
  - A transfer occurs when in_valid && in_ready.
  - Each transfer writes buf[cnt] = in_data, adds sign-extended in_data to a (W+N_LOG2)-bit signed accumulator, and increments cnt.
  - On the transfer with cnt == N-1: go to MEAN, cnt wraps to 0.
  - in_valid without in_ready (any other state) is ignored, with no side effects.
- State MEAN (exactly 1 cycle):
  - mean = acc >>> N_LOG2 (arithmetic shift, floor toward -inf), held as a W-bit signed register.
  - Accumulator cleared. Go to DRAIN.
- State DRAIN:
  - out_valid is registered and rises on the first DRAIN cycle.
  - Latency is 2 cycles from acceptance of the last input to out_valid high.
  - Result for index k: r = 2*mean - buf[k], computed at W+2 bits signed, then reduced to W bits per DIFFUSION_SAT_EN.
  - out_data, out_idx and out_last are registered and held stable while out_valid && !out_ready.
  - On out_valid && out_ready: advance k. Back-to-back transfers at one per cycle when out_ready is held high.
  - After the handshake with out_last high: out_valid = 0 next cycle and state = LOAD.
  - The next frame may be accepted in the cycle after out_valid drops.
- No overlap: input is not accepted during MEAN or DRAIN.
- Reset mid-LOAD or mid-DRAIN: the frame is discarded, outputs return to reset values next cycle, and no partial output is emitted.
- out_ready high while out_valid is low: no effect.

Optional Feature:
- Macro: DIFFUSION_SAT_EN.
- Defined: r is clamped to [-(2^(W-1)), 2^(W-1)-1], i.e. [-128, 127] for W=8.
- Undefined: r is truncated to its low W bits (two's-complement wrap).
- Mean computation is identical in both builds.

Test Plan:
- Ramp with target 3 inverted:
  - Stimulus: inputs 1,2,3,-4,5,6,7,8, out_ready=1.
  - Response: sum 28, mean 3; outputs 5,4,3,10,1,0,-1,-2 at idx 0..7; out_last only on idx 7; first out_valid 2 cycles after the 8th accept.
- Grover uniform case:
  - Stimulus: 32 everywhere except idx 5 = -32.
  - Response: mean 24; out_data = 16 for all idx except idx 5 = 80.
- Negative floor:
  - Stimulus: idx 2 = -3, all others 0.
  - Response: mean -1; outputs -2 everywhere except idx 2 = 1.
- Overflow:
  - Stimulus: idx 0 = -128, others 127.
  - Response: mean 95; idx 0 = 127 with DIFFUSION_SAT_EN, 62 without; others 63 in both builds.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles at idx 3, toggle out_ready randomly elsewhere, and drive in_valid=1 throughout DRAIN.
  - Response: idx 3 data stable while stalled; in_ready=0 throughout; no extra inputs consumed; correct sequence completes.
- Reset mid-operation:
  - Stimulus: assert rst after 4 inputs in one run, and at idx 2 of DRAIN in another.
  - Response: out_valid=0 and in_ready=1 on the cycle after rst deasserts; a following full frame produces correct results (accumulator not polluted).
